// File: rtl/reg_write_ctrl.sv
// -----------------------------------------------------------------------------
// reg_write_ctrl
//
// Upstream write controller for the register bank. Raw board pushbuttons are
// synchronised (two flops), debounced (DEB_CYCLES consecutive stable cycles),
// and edge-detected. The resulting one-cycle pulses drive a small FSM that
// issues clean single-cycle writes on addW/datW/RegWrite. A CLEAR sequence
// writes zero to every address of the bank.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   btn_wr    in   raw write pushbutton (active high, asynchronous)
//   btn_clr   in   raw clear-all pushbutton (active high, asynchronous)
//   auto_inc  in   0: address from sw_addr, 1: address from internal pointer
//   sw_addr   in   switch address  [BIT_ADDR]
//   sw_data   in   switch data     [BIT_DATO]
//   addW      out  registered write address [BIT_ADDR]
//   datW      out  registered write data    [BIT_DATO]
//   RegWrite  out  registered write strobe
//   busy      out  high while CLEAR runs
//   ptr       out  next auto-increment address [BIT_ADDR]
//
// Latency from a clean raw rising edge to RegWrite=1 is DEB_CYCLES+4 edges:
// 2 synchroniser, DEB_CYCLES filter, 1 edge register, 1 output register.
// -----------------------------------------------------------------------------
module reg_write_ctrl #(
    parameter int BIT_ADDR   = 3,
    parameter int BIT_DATO   = 4,
    parameter int DEB_CYCLES = 250000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_wr,
    input  logic                btn_clr,
    input  logic                auto_inc,
    input  logic [BIT_ADDR-1:0] sw_addr,
    input  logic [BIT_DATO-1:0] sw_data,
    output logic [BIT_ADDR-1:0] addW,
    output logic [BIT_DATO-1:0] datW,
    output logic                RegWrite,
    output logic                busy,
    output logic [BIT_ADDR-1:0] ptr
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_ADDR-1:0] ADDR_LAST = {BIT_ADDR{1'b1}};
    localparam logic [BIT_ADDR-1:0] ADDR_ONE  = BIT_ADDR'(1);

    // Button index 0 = write, 1 = clear.
    localparam int B_WR  = 0;
    localparam int B_CLR = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       stable_q, stable_d;
    logic [1:0]       stable_dly_q;
    logic [1:0]       edge_q, edge_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    state_t              state_q, state_d;
    logic [BIT_ADDR-1:0] addr_q, addr_d;
    logic [BIT_DATO-1:0] dat_q, dat_d;
    logic                regwrite_q, regwrite_d;
    logic                busy_q, busy_d;
    logic [BIT_ADDR-1:0] ptr_q, ptr_d;

    logic wr_pulse_s, clr_pulse_s;

    assign wr_pulse_s  = edge_q[B_WR];
    assign clr_pulse_s = edge_q[B_CLR];

    // Debounce filter and rising-edge detection for both buttons.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = cnt_q[i];
            if (sync2_q[i] != stable_q[i]) begin
                // The DEB_CYCLES-th consecutive differing cycle flips the state.
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = '0;
            end
            // Compare against the delayed copy so the pulse lands one edge
            // after the stable value rises.
            edge_d[i] = stable_q[i] & ~stable_dly_q[i];
        end
    end

    // Input conditioning registers: synchronisers, filter state, edge pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            stable_q     <= 2'b00;
            stable_dly_q <= 2'b00;
            edge_q       <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= {btn_clr, btn_wr};
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            edge_q       <= edge_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Transaction FSM: next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dat_d      = dat_q;
        ptr_d      = ptr_q;
        regwrite_d = 1'b0;
        busy_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Clear has priority; a simultaneous write pulse is dropped.
                if (clr_pulse_s) begin
                    state_d    = ST_CLEAR;
                    addr_d     = '0;
                    dat_d      = '0;
                    regwrite_d = 1'b1;
                    busy_d     = 1'b1;
                end else if (wr_pulse_s) begin
                    state_d    = ST_WRITE;
                    dat_d      = sw_data;
                    regwrite_d = 1'b1;
                    if (auto_inc) begin
                        addr_d = ptr_q;
                        ptr_d  = ptr_q + ADDR_ONE;
                    end else begin
                        addr_d = sw_addr;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Strobe is a single cycle; pulses arriving now are discarded.
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                // addr_q doubles as the clear index; datW stays at zero.
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    addr_d     = addr_q + ADDR_ONE;
                    regwrite_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            dat_q      <= '0;
            ptr_q      <= '0;
            regwrite_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dat_q      <= dat_d;
            ptr_q      <= ptr_d;
            regwrite_q <= regwrite_d;
            busy_q     <= busy_d;
        end
    end

    assign addW     = addr_q;
    assign datW     = dat_q;
    assign RegWrite = regwrite_q;
    assign busy     = busy_q;
    assign ptr      = ptr_q;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_write_ctrl
//
// Self-checking bench for reg_write_ctrl (BIT_ADDR=3, BIT_DATO=4,
// DEB_CYCLES=4). A behavioural model tracks, per button, the raw history,
// the run length of disagreement with the accepted level, and the edge on
// which a resulting action is due; a transaction model then produces the
// expected outputs. Outputs are compared on every falling clock edge, and
// directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_reg_write_ctrl;

    localparam int BA  = 3;
    localparam int BD  = 4;
    localparam int DEB = 4;
    localparam int N   = 1 << BA;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_wr = 1'b0;
    logic          btn_clr = 1'b0;
    logic          auto_inc = 1'b0;
    logic [BA-1:0] sw_addr = '0;
    logic [BD-1:0] sw_data = '0;
    logic [BA-1:0] addW;
    logic [BD-1:0] datW;
    logic          RegWrite;
    logic          busy;
    logic [BA-1:0] ptr;

    reg_write_ctrl #(.BIT_ADDR(BA), .BIT_DATO(BD), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst_n), .btn_wr(btn_wr), .btn_clr(btn_clr),
        .auto_inc(auto_inc), .sw_addr(sw_addr), .sw_data(sw_data),
        .addW(addW), .datW(datW), .RegWrite(RegWrite), .busy(busy), .ptr(ptr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_edge;
    bit hist_wr[$];
    bit hist_clr[$];
    int run_wr, run_clr;
    bit acc_wr, acc_clr;
    int due_wr, due_clr;
    int m_addr, m_dat, m_ptr, clr_next;
    bit m_rw, m_busy;

    task automatic model_reset();
        m_edge = 0;
        hist_wr  = '{1'b0, 1'b0};
        hist_clr = '{1'b0, 1'b0};
        run_wr = 0; run_clr = 0;
        acc_wr = 1'b0; acc_clr = 1'b0;
        due_wr = -1; due_clr = -1;
        m_addr = 0; m_dat = 0; m_ptr = 0; clr_next = 0;
        m_rw = 1'b0; m_busy = 1'b0;
    endtask

    // Accepts a new level after DEB consecutive disagreeing samples; returns 1 on a rise.
    function automatic bit filter(input bit s, inout bit acc, inout int run);
        filter = 1'b0;
        if (s != acc) begin
            run++;
            if (run == DEB) begin
                filter = s;
                acc = s;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endfunction

    task automatic model_step();
        bit act_wr, act_clr, s;
        m_edge++;
        act_wr  = (due_wr == m_edge);
        act_clr = (due_clr == m_edge);
        // Transaction layer: pulses are only honoured when nothing is in flight.
        if (m_busy) begin
            if (clr_next == N) begin
                m_rw = 1'b0; m_busy = 1'b0; m_ptr = 0;
            end else begin
                m_addr = clr_next; clr_next++; m_rw = 1'b1;
            end
        end else if (m_rw) begin
            m_rw = 1'b0;
        end else if (act_clr) begin
            m_busy = 1'b1; m_rw = 1'b1; m_addr = 0; m_dat = 0; clr_next = 1;
        end else if (act_wr) begin
            m_rw = 1'b1;
            m_dat = int'(sw_data);
            if (auto_inc) begin
                m_addr = m_ptr;
                m_ptr = (m_ptr + 1) % N;
            end else begin
                m_addr = int'(sw_addr);
            end
        end
        // Input layer: the level seen by the filter is the raw value two edges old.
        s = hist_wr[0];
        hist_wr.push_back(btn_wr);
        void'(hist_wr.pop_front());
        if (filter(s, acc_wr, run_wr)) due_wr = m_edge + 2;
        s = hist_clr[0];
        hist_clr.push_back(btn_clr);
        void'(hist_clr.pop_front());
        if (filter(s, acc_clr, run_clr)) due_clr = m_edge + 2;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- compare + strobe log ----------------
    int strobe_cnt = 0;
    int busy_cnt = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int addr_log[$];
    int dat_log[$];

    task automatic clear_log();
        strobe_cnt = 0; busy_cnt = 0; first_cyc = -1; last_cyc = -1;
        addr_log.delete(); dat_log.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("cyc_RegWrite", 32'(RegWrite), 32'(m_rw));
            check("cyc_busy",     32'(busy),     32'(m_busy));
            check("cyc_addW",     32'(addW),     32'(m_addr));
            check("cyc_datW",     32'(datW),     32'(m_dat));
            check("cyc_ptr",      32'(ptr),      32'(m_ptr));
            if (RegWrite === 1'b1) begin
                strobe_cnt++;
                addr_log.push_back(int'(addW));
                dat_log.push_back(int'(datW));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (busy === 1'b1) busy_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    int t_press;

    task automatic press_wr(input int hold);
        @(negedge clk);
        btn_wr = 1'b1;
        t_press = cyc;
        repeat (hold) @(negedge clk);
        btn_wr = 1'b0;
    endtask

    task automatic press_clr(input int hold);
        @(negedge clk);
        btn_clr = 1'b1;
        repeat (hold) @(negedge clk);
        btn_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int nb;
        idle(3);
        #2 rst_n = 1'b1;
        idle(2);
        #1;
        check("rst_addW", 32'(addW), 32'd0);
        check("rst_datW", 32'(datW), 32'd0);
        check("rst_RegWrite", 32'(RegWrite), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ptr", 32'(ptr), 32'd0);

        // 1: clean press, latency and captured values
        clear_log();
        auto_inc = 1'b0; sw_addr = 3'd5; sw_data = 4'd9;
        press_wr(6);
        idle(14);
        check("t1_strobes", 32'(strobe_cnt), 32'd1);
        check("t1_latency", 32'(first_cyc - t_press), 32'd8);
        check("t1_addW", 32'(addr_log[0]), 32'd5);
        check("t1_datW", 32'(dat_log[0]), 32'd9);

        // 2: bouncing input never reaches the filter threshold
        clear_log();
        sw_addr = 3'd2; sw_data = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); btn_wr = 1'b1;
            idle(2);
            @(negedge clk); btn_wr = 1'b0;
        end
        idle(12);
        check("t2_bounce_strobes", 32'(strobe_cnt), 32'd0);
        press_wr(6);
        idle(14);
        check("t2_clean_strobes", 32'(strobe_cnt), 32'd1);
        check("t2_addW", 32'(addr_log[0]), 32'd2);
        check("t2_datW", 32'(dat_log[0]), 32'd3);

        // 3: auto-increment with wrap
        clear_log();
        auto_inc = 1'b1; sw_addr = 3'd7;
        for (int k = 1; k <= 9; k++) begin
            sw_data = BD'(k);
            press_wr(6);
            idle(10);
        end
        check("t3_strobes", 32'(strobe_cnt), 32'd9);
        for (int i = 0; i < 9 && i < addr_log.size(); i++) begin
            check("t3_addr_seq", 32'(addr_log[i]), 32'(i % 8));
            check("t3_data_seq", 32'(dat_log[i]), 32'(i + 1));
        end
        check("t3_ptr", 32'(ptr), 32'd1);
        check("t3_model_ptr", 32'(m_ptr), 32'd1);

        // 4: clear sequence
        clear_log();
        auto_inc = 1'b0;
        press_clr(6);
        idle(16);
        check("t4_strobes", 32'(strobe_cnt), 32'd8);
        check("t4_busy_cycles", 32'(busy_cnt), 32'd8);
        check("t4_consecutive", 32'(last_cyc - first_cyc), 32'd7);
        for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
            check("t4_addr", 32'(addr_log[i]), 32'(i));
            check("t4_data", 32'(dat_log[i]), 32'd0);
        end
        check("t4_ptr", 32'(ptr), 32'd0);
        check("t4_busy_end", 32'(busy), 32'd0);

        // 5a: simultaneous presses -> clear only
        clear_log();
        sw_addr = 3'd3; sw_data = 4'hF;
        @(negedge clk); btn_wr = 1'b1; btn_clr = 1'b1;
        idle(4);
        btn_wr = 1'b0; btn_clr = 1'b0;
        idle(14);
        check("t5_strobes", 32'(strobe_cnt), 32'd8);
        for (int i = 0; i < 8 && i < dat_log.size(); i++) begin
            check("t5_data", 32'(dat_log[i]), 32'd0);
        end
        // 5b: write edge landing mid-clear is dropped
        clear_log();
        @(negedge clk); btn_clr = 1'b1;
        idle(3);
        btn_wr = 1'b1;
        idle(1);
        btn_clr = 1'b0;
        idle(3);
        btn_wr = 1'b0;
        idle(20);
        check("t5b_strobes", 32'(strobe_cnt), 32'd8);
        check("t5b_model_strobes_pin", 32'(m_addr), 32'd7);
        for (int i = 0; i < 8 && i < dat_log.size(); i++) begin
            check("t5b_data", 32'(dat_log[i]), 32'd0);
        end

        // 6: asynchronous reset in the third clear cycle
        clear_log();
        auto_inc = 1'b1;
        press_wr(6);
        idle(14);
        press_clr(6);
        nb = 0;
        for (int i = 0; i < 30 && nb < 3; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
        end
        check("t6_busy_seen", 32'(nb), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_RegWrite", 32'(RegWrite), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_addW", 32'(addW), 32'd0);
        check("t6_rst_datW", 32'(datW), 32'd0);
        check("t6_rst_ptr", 32'(ptr), 32'd0);
        idle(3);
        #2 rst_n = 1'b1;
        clear_log();
        idle(20);
        check("t6_no_strobes", 32'(strobe_cnt), 32'd0);

        // Random phase: random levels and hold times on both buttons.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            btn_wr   = ($urandom_range(0, 2) == 0);
            btn_clr  = ($urandom_range(0, 6) == 0);
            auto_inc = $urandom_range(0, 1) == 1;
            sw_addr  = BA'($urandom);
            sw_data  = BD'($urandom);
            idle($urandom_range(0, 9));
        end
        btn_wr = 1'b0; btn_clr = 1'b0;
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_write_ctrl.md
Name: reg_write_ctrl

Overview:
Upstream write controller for the register bank. Turns raw board pushbuttons and switches into clean, single-cycle write transactions on addW/datW/RegWrite. Includes 2-flop synchronisers, per-button debounce filters, and an auto-increment write pointer. A CLEAR sequence writes zero to every register address. Outputs connect directly to the register bank's write port.

Parameters:
BIT_ADDR, 3, register address width; bank depth = 2^BIT_ADDR
BIT_DATO, 4, data word width
DEB_CYCLES, 250000, consecutive stable cycles required to accept a button change (5 ms at 50 MHz; bench uses 4)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
btn_wr  input  1  raw write pushbutton, active-high, asynchronous to clk
btn_clr  input  1  raw clear-all pushbutton, active-high, asynchronous to clk
auto_inc  input  1  0 = address from sw_addr; 1 = address from internal pointer
sw_addr  input  BIT_ADDR  switch address
sw_data  input  BIT_DATO  switch data
addW  output  BIT_ADDR  registered write address
datW  output  BIT_DATO  registered write data
RegWrite  output  1  registered write strobe
busy  output  1  high while CLEAR runs
ptr  output  BIT_ADDR  next auto-increment address (for display/LED)

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; synchronisers, debounce counters and stable states 0; ptr=0; FSM=IDLE. Reset mid-CLEAR aborts the sequence; no further strobes after release.
- Synchroniser: two flops per button. Inputs auto_inc, sw_addr and sw_data are sampled unsynchronised, at capture time only.
- Debounce, per button:
  - counter counts while the synchronised value differs from the stable value;
  - any cycle where they match clears the counter;
  - when the counter reaches DEB_CYCLES, the stable value takes the synchronised value and the counter clears.
- Edge detect: one-cycle pulse on each rising edge of the stable value. Falling edges produce no action.
- Latency: from a clean raw rising edge to RegWrite=1 is exactly DEB_CYCLES+4 clk edges:
  - 2 for synchronisation;
  - DEB_CYCLES for the filter;
  - 1 for the edge register;
  - 1 for the output register.
- FSM states: IDLE, WRITE, CLEAR.
  - IDLE, clr pulse: go to CLEAR, with clear index = 0.
  - IDLE, wr pulse (and no clr pulse): go to WRITE.
    - Capture addW = auto_inc ? ptr : sw_addr, and datW = sw_data.
    - If auto_inc=1, ptr increments modulo 2^BIT_ADDR (2^BIT_ADDR-1 wraps to 0).
  - Simultaneous wr and clr pulses: clr wins; the wr pulse is dropped.
  - WRITE: RegWrite=1 for exactly this one cycle, then IDLE.
  - CLEAR: RegWrite=1 and busy=1 every cycle; addW = index and datW = 0, with index running 0 to 2^BIT_ADDR-1.
    - After the last address, go to IDLE with ptr=0, and RegWrite=0 and busy=0 on the next cycle.
    - CLEAR therefore lasts exactly 2^BIT_ADDR cycles.
  - Edge pulses arriving during WRITE or CLEAR are discarded (not queued).
- Hold behaviour:
  - addW and datW hold their last values while RegWrite=0.
  - A button held high gives exactly one transaction per press; auto-repeat is not supported.
- Glitches shorter than DEB_CYCLES cycles (after synchronisation) never change the stable state and never produce a write.

Test Plan:
1. Reset, then DEB_CYCLES=4, auto_inc=0, sw_addr=5, sw_data=9, clean btn_wr press -> RegWrite pulses high exactly once, 8 cycles after the press, with addW=5 and datW=9; all outputs 0 before the pulse.
2. Bounce btn_wr high for 3 cycles, low for 1, repeated 5 times, then release -> no RegWrite; a clean press afterwards gives exactly one pulse.
3. auto_inc=1 and 9 presses with sw_data=1..9 -> addW sequence 0,1,...,7,0; ptr=1 at the end (wrap checked).
4. btn_clr press -> busy and RegWrite high for exactly 8 consecutive cycles, addW=0..7, datW=0; then ptr=0, busy=0.
5. btn_wr and btn_clr pressed on the same cycle -> only the CLEAR sequence (8 strobes), no data write; a btn_wr edge during CLEAR is dropped.
6. Assert rst at the 3rd CLEAR cycle -> RegWrite, busy, addW, datW and ptr are 0 immediately (asynchronous); no strobes after release until a new press.
